// File: rtl/mvp_pkg.sv
// Shared types and defaults for the mvp datapath and its result drain.
// lane_w() gives the width of one lane of mvp's packed popcount output.
package mvp_pkg;

    typedef enum logic {
        EMPTY,
        DRAIN
    } drain_state_t;

    localparam int N_DEF    = 32;
    localparam int ACCW_DEF = 16;
    localparam int PREC_DEF = 8;

    function automatic int lane_w(input int n);
        return $clog2(n) + 2;
    endfunction

endpackage

// File: rtl/mvp_lane_acc.sv
// One lane's bit-plane accumulator: acc <= (fresh ? 0 : acc << 1) +/- x.
// acc_nxt is exposed so the drain can capture a finishing vector on the same edge.
module mvp_lane_acc
    import mvp_pkg::*;
#(
    parameter int ACCW = ACCW_DEF,
    parameter int XW   = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            fresh,
    input  logic            neg,
    input  logic [XW-1:0]   x,
    output logic [ACCW-1:0] acc,
    output logic [ACCW-1:0] acc_nxt
);

    logic signed [XW-1:0] x_s;
    logic [ACCW-1:0]      x_ext;
    logic [ACCW-1:0]      base;
    logic [ACCW-1:0]      addend;

    assign x_s     = x;
    assign x_ext   = ACCW'(x_s);
    assign base    = fresh ? '0 : {acc[ACCW-2:0], 1'b0};
    assign addend  = neg ? -x_ext : x_ext;
    assign acc_nxt = base + addend;

    // NOTE: registers update with <= so every lane samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/mvp_result_drain.sv
// Accumulates mvp's per-lane popcount planes (MSB first) into signed words and
// serialises each finished vector one lane per beat, with one vector of slack.
module mvp_result_drain
    import mvp_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int A    = $clog2(N),
    parameter int ACCW = ACCW_DEF,
    parameter int PREC = PREC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N*(A+2)-1:0] s_data,
    input  logic               s_neg,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ACCW-1:0]    m_data,
    output logic [A-1:0]       m_lane,
    output logic               m_last,
    output logic               ovf_err
);

    localparam int             LW        = lane_w(N);
    localparam int             PCW       = $clog2(PREC + 1);
    localparam logic [A-1:0]   LAST_LANE = A'(N - 1);
    localparam logic [PCW-1:0] CNT_MAX   = PCW'(PREC - 1);

    drain_state_t    state, state_nxt;
    logic [A-1:0]    lane, lane_nxt;
    logic            pend, pend_nxt;
    logic            fresh;
    logic [PCW-1:0]  plane_cnt;
    logic            load_new, load_acc;

    logic [ACCW-1:0] acc     [N];
    logic [ACCW-1:0] acc_nxt [N];
    logic [ACCW-1:0] shadow  [N];

    logic accept, final_beat, forced, out_hs, last_hs;

    assign accept     = s_valid && s_ready;
    assign final_beat = accept && (s_last || plane_cnt == CNT_MAX);
    assign forced     = accept && !s_last && plane_cnt == CNT_MAX;
    assign out_hs     = m_valid && m_ready;
    assign last_hs    = out_hs && lane == LAST_LANE;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            mvp_lane_acc #(
                .ACCW (ACCW),
                .XW   (LW)
            ) u_lane_acc (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (accept),
                .fresh   (fresh),
                .neg     (s_neg),
                .x       (s_data[gi*LW +: LW]),
                .acc     (acc[gi]),
                .acc_nxt (acc_nxt[gi])
            );
        end
    endgenerate

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        pend_nxt  = pend;
        load_new  = 1'b0;
        load_acc  = 1'b0;
        case (state)
            EMPTY: begin
                if (final_beat) begin
                    state_nxt = DRAIN;
                    lane_nxt  = '0;
                    load_new  = 1'b1;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    lane_nxt = lane + A'(1);
                end
                if (last_hs) begin
                    lane_nxt = '0;
                    if (pend) begin
                        load_acc = 1'b1;
                        pend_nxt = 1'b0;
                    end else if (final_beat) begin
                        load_new = 1'b1;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end else if (final_beat) begin
                    // Shadow is still busy: park the finished vector in acc.
                    pend_nxt = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            lane      <= '0;
            pend      <= 1'b0;
            fresh     <= 1'b1;
            plane_cnt <= '0;
            ovf_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            lane  <= lane_nxt;
            pend  <= pend_nxt;
            if (accept) begin
                fresh     <= final_beat;
                plane_cnt <= final_beat ? '0 : plane_cnt + PCW'(1);
            end
            if (forced) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // NOTE: shadow is reset because it drives m_data directly; leaving it unreset would expose X.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                shadow[i] <= '0;
            end else if (load_new) begin
                shadow[i] <= acc_nxt[i];
            end else if (load_acc) begin
                shadow[i] <= acc[i];
            end
        end
    end

    assign s_ready = !pend;
    assign m_valid = (state == DRAIN);
    assign m_data  = shadow[lane];
    assign m_lane  = lane;
    assign m_last  = (state == DRAIN) && (lane == LAST_LANE);

endmodule

// File: tb/tb_mvp_result_drain.sv
// Bench for mvp_result_drain (N=4, ACCW=16, PREC=2): an arithmetic reference
// model fills a scoreboard on every accepted plane; a monitor checks each output word.
module tb_mvp_result_drain;

    localparam int N    = 4;
    localparam int A    = 2;
    localparam int ACCW = 16;
    localparam int PREC = 2;
    localparam int LW   = A + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [N*LW-1:0]    s_data = '0;
    logic               s_neg = 1'b0;
    logic               s_last = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [ACCW-1:0]    m_data;
    logic [A-1:0]       m_lane;
    logic               m_last;
    logic               ovf_err;

    always #5 clk = ~clk;

    mvp_result_drain #(
        .N    (N),
        .A    (A),
        .ACCW (ACCW),
        .PREC (PREC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_neg   (s_neg),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_lane  (m_lane),
        .m_last  (m_last),
        .ovf_err (ovf_err)
    );

    typedef struct {
        logic [ACCW-1:0] data;
        logic [A-1:0]    lane;
        logic            last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;
    int rdy_mode = 0;   // 0 manual, 1 pattern 1,0,0 repeating, 2 random
    int tog_i    = 0;

    // Reference model: running per-lane value and plane count of the open vector.
    int m_r [N];
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    logic            held = 1'b0;
    logic [ACCW-1:0] held_data;
    logic [A-1:0]    held_lane;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic model_beat(input int xs[N], input bit neg, input bit last);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            m_r[i] = (m_cnt == 0 ? 0 : 2 * m_r[i]) + (neg ? -xs[i] : xs[i]);
        end
        m_cnt++;
        if (last || m_cnt == PREC) begin
            if (!last) m_ovf = 1'b1;
            for (int i = 0; i < N; i++) begin
                e.data = ACCW'(m_r[i]);
                e.lane = A'(i);
                e.last = (i == N - 1);
                exp_q.push_back(e);
            end
            m_cnt = 0;
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input int xs[N], input bit neg, input bit last);
        bit ok = 1'b0;
        int waited = 0;
        for (int i = 0; i < N; i++) s_data[i*LW +: LW] = LW'(xs[i]);
        s_neg   = neg;
        s_last  = last;
        s_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            if (!ok) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL s_ready_timeout actual=0 required=1 @%0t", $time);
                    break;
                end
            end
        end
        if (ok) model_beat(xs, neg, last);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_neg   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || m_valid) && n < 500);
        check({name, "_drained"}, {31'd0, exp_q.size() == 0 && !m_valid}, 32'd1);
        sync();
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                m_ready = (tog_i == 0);
                tog_i   = (tog_i + 1) % 3;
            end
            2: m_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Monitor: stall stability and scoreboard comparison on every handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_hold", {13'd0, m_valid, m_lane, m_data}, {13'd0, 1'b1, held_lane, held_data});
            end
            if (m_valid && m_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=0x%0h required=none @%0t", m_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(mon_e.data));
                    check("m_lane", 32'(m_lane), 32'(mon_e.lane));
                    check("m_last", 32'(m_last), 32'(mon_e.last));
                end
            end
            held      = m_valid && !m_ready;
            held_data = m_data;
            held_lane = m_lane;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xs[N];
        int np;
        int base;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_m_lane",  32'(m_lane),  32'd0);
        check("rst_m_last",  32'(m_last),  32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        sync();
        rst_n = 1'b1;

        // Two planes, unsigned: 2,5,6,9 with latency 1
        m_ready = 1'b1;
        send_beat('{1, 2, 3, 4}, 1'b0, 1'b0);
        send_beat('{0, 1, 0, 1}, 1'b0, 1'b1);
        @(negedge clk);
        check("latency_m_valid", 32'(m_valid), 32'd1);
        wait_drain("two_planes");

        // Signed MSB plane: -1,-2,-1,-2
        send_beat('{1, 1, 1, 1}, 1'b1, 1'b0);
        send_beat('{1, 0, 1, 0}, 1'b0, 1'b1);
        wait_drain("signed");

        // Backpressure 1,0,0 pattern: exactly four handshakes
        rdy_mode = 1;
        base = hs_count;
        send_beat('{3, -2, 1, 7}, 1'b0, 1'b0);
        send_beat('{-8, 4, 0, 2}, 1'b0, 1'b1);
        wait_drain("backpressure");
        check("bp_handshakes", 32'(hs_count - base), 32'd4);
        rdy_mode = 0;

        // Pend: second vector parks in acc while the first is stalled
        m_ready = 1'b0;
        send_beat('{4, 4, 4, 4}, 1'b0, 1'b1);
        send_beat('{1, 2, 3, 0}, 1'b0, 1'b1);
        @(negedge clk);
        check("pend_s_ready_low", 32'(s_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            check("pend_no_bubble", 32'(m_valid), 32'd1);
        end
        @(negedge clk);
        check("pend_s_ready_back", 32'(s_ready), 32'd1);
        check("pend_empty", 32'(m_valid), 32'd0);
        sync();

        // Overrun: PREC planes without s_last close the vector and set ovf_err
        send_beat('{1, 1, 1, 1}, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_clear_first", 32'(ovf_err), 32'd0);
        sync();
        send_beat('{1, 1, 1, 1}, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_set", 32'(ovf_err), 32'd1);
        sync();
        send_beat('{1, 1, 1, 1}, 1'b0, 1'b0);
        send_beat('{0, 0, 0, 0}, 1'b0, 1'b1);
        wait_drain("overrun");
        @(negedge clk);
        check("ovf_sticky", 32'(ovf_err), 32'(m_ovf));
        sync();

        // Reset mid-drain at lane 2
        send_beat('{2, 1, 0, 3}, 1'b0, 1'b0);
        send_beat('{1, 1, 1, 1}, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid && m_lane == 2) && n < 20);
        check("reach_lane2", {31'd0, m_valid && m_lane == 2}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_m_valid", 32'(m_valid), 32'd0);
        check("rstmid_s_ready", 32'(s_ready), 32'd1);
        check("rstmid_ovf_err", 32'(ovf_err), 32'd0);
        check("rstmid_m_lane",  32'(m_lane),  32'd0);
        sync();
        send_beat('{1, 2, 3, 4}, 1'b0, 1'b1);
        wait_drain("after_reset");

        // Randomized vectors, random m_ready
        rdy_mode = 2;
        for (int v = 0; v < 40; v++) begin
            np = $urandom_range(1, PREC);
            for (int p = 0; p < np; p++) begin
                for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 15)) - 8;
                send_beat(xs, ($urandom_range(0, 3) == 0),
                          (p == np - 1) && ($urandom_range(0, 3) != 0));
            end
            repeat ($urandom_range(0, 2)) sync();
        end
        wait_drain("random");
        @(negedge clk);
        check("random_ovf", 32'(ovf_err), 32'(m_ovf));
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
